// File: rtl/ofs_fim_axis_pkt_arb_if.sv
// AXI-S bundle for the packet arbiter: LANES parallel streams packed lane-major,
// plus the source index carried alongside the merged stream.
interface ofs_fim_axis_pkt_arb_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 10,
    parameter int SRC_W      = 1
);
    logic [LANES-1:0]            tvalid;
    logic [LANES-1:0]            tready;
    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic [LANES*KEEP_WIDTH-1:0] tkeep;
    logic [LANES*USER_WIDTH-1:0] tuser_vendor;
    logic [LANES-1:0]            tlast;
    logic [SRC_W-1:0]            src_id;

    modport master (
        output tvalid, tdata, tkeep, tuser_vendor, tlast, src_id,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tuser_vendor, tlast, src_id,
        output tready
    );
endinterface

// File: rtl/ofs_fim_axis_pkt_arb.sv
// Packet-level round-robin arbiter merging NUM_INPUTS AXI-S sources into one registered stream.
// Define OFS_FIM_AXIS_PKT_ARB_HIPRI_EN to make input 0 strict high priority at packet boundaries.
module ofs_fim_axis_pkt_arb #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 10,
    localparam int SRC_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ofs_fim_axis_pkt_arb_if.slave  s,
    ofs_fim_axis_pkt_arb_if.master m
);
    localparam int unsigned N = NUM_INPUTS;
`ifdef OFS_FIM_AXIS_PKT_ARB_HIPRI_EN
    localparam bit HIPRI = 1'b1;
`else
    localparam bit HIPRI = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state;
    logic [SRC_W-1:0]       rr_ptr;
    logic [SRC_W-1:0]       gnt;
    logic [SRC_W-1:0]       win;
    logic [SRC_W-1:0]       cand;
    logic [SRC_W-1:0]       sel;
    logic                   win_vld;
    logic                   run;
    logic                   out_rdy;
    logic                   accept;
    int unsigned            idx;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [KEEP_WIDTH-1:0]  sel_keep;
    logic [USER_WIDTH-1:0]  sel_user;
    logic                   sel_last;

    assign out_rdy = !m.tvalid[0] || m.tready[0];
    assign sel     = (state == IDLE) ? win : gnt;
    assign accept  = run && out_rdy && ((state == IDLE) ? win_vld : s.tvalid[gnt]);

    // Rotating search starting one past the last first-beat winner.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        idx     = 0;
        if (HIPRI && s.tvalid[0]) begin
            win_vld = 1'b1;
        end
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = SRC_W'(idx);
            if (!win_vld && !(HIPRI && cand == '0) && s.tvalid[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    // run keeps every s_tready low from the instant reset asserts.
    always_comb begin
        s.tready = '0;
        if (run) begin
            if (state == IDLE) begin
                if (win_vld) begin
                    s.tready[win] = out_rdy;
                end
            end else begin
                s.tready[gnt] = out_rdy;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_keep = '0;
        sel_user = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (SRC_W'(i) == sel) begin
                sel_data = s.tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep = s.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_user = s.tuser_vendor[i*USER_WIDTH +: USER_WIDTH];
                sel_last = s.tlast[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= SRC_W'(NUM_INPUTS - 1);
            gnt      <= '0;
            run      <= 1'b0;
            m.tvalid <= '0;
            m.tlast  <= '0;
            m.src_id <= '0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                m.tvalid <= 1'b1;
                m.tlast  <= sel_last;
                m.src_id <= sel;
            end else if (m.tready[0]) begin
                m.tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!(HIPRI && win == '0)) begin
                            rr_ptr <= win;
                        end
                        if (!sel_last) begin
                            gnt   <= win;
                            state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (accept && sel_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            m.tdata        <= sel_data;
            m.tkeep        <= sel_keep;
            m.tuser_vendor <= sel_user;
        end
    end
endmodule

// File: tb/tb_ofs_fim_axis_pkt_arb.sv
// Scoreboard bench for ofs_fim_axis_pkt_arb: accepted input beats are queued and matched
// against the merged output; grant-order scenarios are compared against fixed sequences.
module tb_ofs_fim_axis_pkt_arb;
    localparam int NI = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int UW = 10;
    localparam int SW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        int unsigned   hold;
        int unsigned   src;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ofs_fim_axis_pkt_arb_if #(.LANES(NI), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                              .USER_WIDTH(UW), .SRC_W(SW)) s_if ();
    ofs_fim_axis_pkt_arb_if #(.LANES(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                              .USER_WIDTH(UW), .SRC_W(SW)) m_if ();

    ofs_fim_axis_pkt_arb #(
        .NUM_INPUTS(NI),
        .DATA_WIDTH(DW),
        .KEEP_WIDTH(KW),
        .USER_WIDTH(UW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s_if),
        .m     (m_if)
    );

    beat_t         src_q[NI][$];
    beat_t         sb[$];
    int unsigned   hold_cnt[NI];
    bit            fresh[NI];
    bit            acc[NI];
    int            lock;
    bit            acc_prev;
    int unsigned   acc_prev_src;
    int unsigned   acc_total;
    bit            stall_prev;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_src;
    logic          prev_last;
    int unsigned   out_log[$];
    int unsigned   out_cyc[$];
    int unsigned   exp_seq[$];
    int unsigned   exp_gap[$];
    int unsigned   pkt_id;
    int unsigned   cyc;
    int unsigned   tr_mode;
    bit            tr_tog;
    int unsigned   t7_beats;
    int            n_tests;
    int            n_fail;

    task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_pkt(int unsigned src, int unsigned len, int unsigned first_hold,
                           int unsigned gap_beat, int unsigned gap_len);
        beat_t b;
        for (int unsigned k = 0; k < len; k++) begin
            b.data = {8'(src), 8'(pkt_id), 8'(k), 8'($urandom)};
            b.keep = KW'($urandom);
            b.user = UW'($urandom);
            b.last = (k == len - 1);
            b.hold = (k == 0) ? first_hold : ((k == gap_beat) ? gap_len : 0);
            b.src  = src;
            src_q[src].push_back(b);
        end
        pkt_id++;
    endtask

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            if (acc[i]) begin
                acc[i] = 1'b0;
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                fresh[i] = 1'b1;
            end
            if (src_q[i].size() == 0) begin
                s_if.tvalid[i] = 1'b0;
                fresh[i] = 1'b1;
            end else begin
                if (fresh[i]) begin
                    hold_cnt[i] = src_q[i][0].hold;
                    fresh[i] = 1'b0;
                end
                s_if.tdata[i*DW +: DW]        = src_q[i][0].data;
                s_if.tkeep[i*KW +: KW]        = src_q[i][0].keep;
                s_if.tuser_vendor[i*UW +: UW] = src_q[i][0].user;
                s_if.tlast[i]                 = src_q[i][0].last;
                if (hold_cnt[i] > 0) begin
                    s_if.tvalid[i] = 1'b0;
                    hold_cnt[i]--;
                end else begin
                    s_if.tvalid[i] = 1'b1;
                end
            end
        end
        case (tr_mode)
            0: m_if.tready = 1'b1;
            1: begin
                tr_tog = !tr_tog;
                m_if.tready = tr_tog;
            end
            default: m_if.tready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic monitor();
        beat_t       e;
        int unsigned n_rdy;
        if (stall_prev) begin
            check_val("hold_data", m_if.tdata, prev_data);
            check_val("hold_src", m_if.src_id, prev_src);
            check_val("hold_last", m_if.tlast, prev_last);
        end
        if (acc_prev) begin
            check_val("lat_valid", m_if.tvalid, 1);
            check_val("lat_src", m_if.src_id, acc_prev_src);
        end
        if (m_if.tvalid[0] && m_if.tready[0]) begin
            if (sb.size() == 0) begin
                check_val("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check_val("out_src", m_if.src_id, e.src);
                check_val("out_data", m_if.tdata, e.data);
                check_val("out_keep", m_if.tkeep, e.keep);
                check_val("out_user", m_if.tuser_vendor, e.user);
                check_val("out_last", m_if.tlast, e.last);
            end
            out_log.push_back(32'(m_if.src_id));
            out_cyc.push_back(cyc);
        end
        acc_prev = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < NI; i++) begin
            if (s_if.tready[i]) n_rdy++;
            if (lock >= 0 && i != lock) check_val("rdy_while_locked", s_if.tready[i], 0);
        end
        check_val("one_ready", (n_rdy <= 1), 1);
        for (int i = 0; i < NI; i++) begin
            if (s_if.tvalid[i] && s_if.tready[i]) begin
                e = src_q[i][0];
                sb.push_back(e);
                acc[i] = 1'b1;
                acc_prev = 1'b1;
                acc_prev_src = i;
                acc_total++;
                lock = e.last ? -1 : i;
            end
        end
        stall_prev = m_if.tvalid[0] && !m_if.tready[0];
        prev_data  = m_if.tdata;
        prev_src   = m_if.src_id;
        prev_last  = m_if.tlast[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        monitor();
        cyc++;
    endtask

    task automatic flush();
        for (int i = 0; i < NI; i++) begin
            src_q[i].delete();
            acc[i] = 1'b0;
            fresh[i] = 1'b1;
        end
        sb.delete();
        lock = -1;
        acc_prev = 1'b0;
        stall_prev = 1'b0;
    endtask

    task automatic drain(string tag);
        bit done;
        bit empty;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            step();
            empty = (sb.size() == 0) && !m_if.tvalid[0];
            for (int i = 0; i < NI; i++) if (src_q[i].size() != 0) empty = 1'b0;
            done = empty;
        end
        check_val({tag, "_drain"}, done, 1);
    endtask

    task automatic check_seq(string tag);
        check_val({tag, "_len"}, out_log.size(), exp_seq.size());
        for (int k = 0; k < out_log.size() && k < exp_seq.size(); k++)
            check_val({tag, "_src"}, out_log[k], exp_seq[k]);
        for (int k = 1; k < out_cyc.size() && k <= exp_gap.size(); k++)
            check_val({tag, "_gap"}, out_cyc[k] - out_cyc[k-1], exp_gap[k-1]);
    endtask

    task automatic new_test();
        out_log.delete();
        out_cyc.delete();
        exp_gap.delete();
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        pkt_id = 0;
        cyc = 0;
        tr_mode = 0;
        tr_tog = 1'b0;
        acc_total = 0;
        s_if.tvalid = '0;
        s_if.tdata = '0;
        s_if.tkeep = '0;
        s_if.tuser_vendor = '0;
        s_if.tlast = '0;
        s_if.src_id = '0;
        m_if.tready = 1'b1;
        flush();

        // Reset state with all inputs already requesting
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NI; i++) add_pkt(i, 1, 0, 99, 0);
        repeat (3) step();
        check_val("rst_m_tvalid", m_if.tvalid, 0);
        check_val("rst_m_tlast", m_if.tlast, 0);
        check_val("rst_m_src_id", m_if.src_id, 0);
        check_val("rst_s_tready", s_if.tready, 0);
        rst_n = 1'b1;

        // T1: all inputs single beats, consecutive rotation
        new_test();
        drain("t1");
`ifdef OFS_FIM_AXIS_PKT_ARB_HIPRI_EN
        exp_seq = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        exp_gap = '{1, 1, 1, 1, 1, 1, 1};
        check_seq("t1");

        // T2: 3-beat packet on in0 holds grant against in1
        new_test();
        add_pkt(0, 3, 0, 99, 0);
        add_pkt(1, 1, 0, 99, 0);
        drain("t2");
        exp_seq = '{0, 0, 0, 1};
        exp_gap = '{1, 1, 1};
        check_seq("t2");

        // T3: downstream backpressure toggling during a 4-beat packet
        new_test();
        tr_mode = 1;
        add_pkt(2, 4, 0, 99, 0);
        drain("t3");
        tr_mode = 0;
        exp_seq = '{2, 2, 2, 2};
        check_seq("t3");

        // T4: in2 pauses 2 cycles mid-packet, in3 must wait for tlast
        new_test();
        add_pkt(2, 4, 0, 2, 2);
        add_pkt(3, 1, 1, 99, 0);
        drain("t4");
        exp_seq = '{2, 2, 2, 2, 3};
        exp_gap = '{1, 3, 1, 1};
        check_seq("t4");

        // T5: reset during beat 2 of a 4-beat packet
        new_test();
        acc_total = 0;
        add_pkt(0, 4, 0, 99, 0);
        for (int k = 0; k < 50 && acc_total < 2; k++) step();
        check_val("t5_reach_beat2", (acc_total >= 2), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_m_tvalid", m_if.tvalid, 0);
        check_val("t5_rst_s_tready", s_if.tready, 0);
        flush();
        repeat (3) step();
        check_val("t5_rst_hold_tvalid", m_if.tvalid, 0);
        rst_n = 1'b1;
        new_test();
        for (int i = 0; i < NI; i++) add_pkt(i, 1, 0, 99, 0);
        drain("t5");
        exp_seq = '{0, 1, 2, 3};
        exp_gap = '{1, 1, 1};
        check_seq("t5");

        // T6: in0 and in1 continuously requesting single beats
        new_test();
        for (int r = 0; r < 4; r++) begin
            add_pkt(0, 1, 0, 99, 0);
            add_pkt(1, 1, 0, 99, 0);
        end
        drain("t6");
`ifdef OFS_FIM_AXIS_PKT_ARB_HIPRI_EN
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        check_seq("t6");

        // T7: random packet lengths, source gaps and backpressure
        new_test();
        tr_mode = 2;
        t7_beats = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NI; i++) begin
                int unsigned len;
                len = $urandom_range(1, 4);
                t7_beats += len;
                add_pkt(i, len, $urandom_range(0, 1), $urandom_range(1, 3), $urandom_range(0, 2));
            end
        end
        drain("t7");
        tr_mode = 0;
        check_val("t7_count", out_log.size(), t7_beats);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
